// File: rtl/taxi_pcie_tlp_pkg.sv
// TLP header field definitions shared by the PCIe interrupt receive path.
package taxi_pcie_tlp_pkg;

  localparam logic [2:0] FMT_3DW_DATA = 3'b010;
  localparam logic [2:0] FMT_4DW_DATA = 3'b011;
  localparam logic [4:0] TYPE_MEM     = 5'b00000;

  // Bit offsets of each header DW within the 128-bit header bus
  localparam int HDR_DW0_LSB = 96;
  localparam int HDR_DW1_LSB = 64;
  localparam int HDR_DW2_LSB = 32;
  localparam int HDR_DW3_LSB = 0;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [4:0]  typ;
    logic [13:0] misc;     // TC/attr/TH/TD/EP/AT, not decoded here
    logic [9:0]  length;
  } tlp_dw0_t;

  typedef struct packed {
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [3:0]  last_be;
    logic [3:0]  first_be;
  } tlp_dw1_t;

  typedef enum logic {ST_IDLE, ST_DISCARD} rx_state_t;

endpackage

// File: rtl/taxi_pcie_msix_rx_fifo.sv
// Synchronous IRQ index FIFO with registered output. The output register
// shadows the head slot, so capacity is exactly DEPTH entries.
module taxi_pcie_msix_rx_fifo #(
  parameter int DATA_W = 11,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              push,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, rd_next;
  logic              pop;

  assign pop     = out_valid && out_ready;
  assign rd_next = rd_ptr + {{AW{1'b0}}, pop};
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);

  // Storage write; the head slot is only reused after it has been popped
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  // Pointer update and registered head output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr    <= rd_next;
      out_valid <= (wr_ptr != rd_next);
      out_data  <= mem[rd_next[AW-1:0]];
    end
  end

endmodule

// File: rtl/taxi_pcie_msix_rx.sv
// MSI/MSI-X write receiver: decodes single-DW memory writes hitting the
// configured window and queues the interrupt index on an AXI-stream.
module taxi_pcie_msix_rx
  import taxi_pcie_tlp_pkg::*;
#(
  parameter int IRQ_INDEX_W = 11,
  parameter int TLP_DATA_W  = 64,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [127:0]           rx_tlp_hdr,
  input  logic [TLP_DATA_W-1:0]  rx_tlp_data,
  input  logic                   rx_tlp_sop,
  input  logic                   rx_tlp_eop,
  input  logic                   rx_tlp_valid,
  output logic                   rx_tlp_ready,
  output logic [IRQ_INDEX_W-1:0] m_axis_irq_tdata,
  output logic                   m_axis_irq_tvalid,
  input  logic                   m_axis_irq_tready,
  input  logic [63:0]            msi_base_addr,
  input  logic [63:0]            msi_addr_mask,
  input  logic                   enable,
  output logic                   stat_irq,
  output logic                   stat_drop_bad,
  output logic                   stat_drop_ovf,
  output logic                   ovf_sticky,
  input  logic                   ovf_clear
);

  rx_state_t        state;
  tlp_dw0_t         dw0;
  tlp_dw1_t         dw1;
  logic [63:0]      addr;
  logic [31:0]      pay;
  logic             accept, hdr_ok, addr_ok, pass;
  logic             dec_pass, dec_bad;
  logic [IRQ_INDEX_W-1:0] dec_idx;
  logic             fifo_full, fifo_empty, push, pop;
  logic             unused_bits;

  assign accept = rx_tlp_valid && rx_tlp_ready;
  assign dw0    = tlp_dw0_t'(rx_tlp_hdr[HDR_DW0_LSB +: 32]);
  assign dw1    = tlp_dw1_t'(rx_tlp_hdr[HDR_DW1_LSB +: 32]);
  assign pay    = rx_tlp_data[31:0];

  // Fields the decoder deliberately ignores
  assign unused_bits = ^{dw0.misc, dw1.req_id, dw1.tag, rx_tlp_hdr[HDR_DW3_LSB +: 2],
                         rx_tlp_data[TLP_DATA_W-1:32], fifo_empty};

  // Address extraction for 3DW and 4DW headers, then the window check
  always_comb begin
    if (dw0.fmt == FMT_4DW_DATA)
      addr = {rx_tlp_hdr[HDR_DW2_LSB +: 32], rx_tlp_hdr[HDR_DW3_LSB + 2 +: 30], 2'b00};
    else
      addr = {32'h0, rx_tlp_hdr[HDR_DW2_LSB + 2 +: 30], 2'b00};
    hdr_ok  = ((dw0.fmt == FMT_3DW_DATA) || (dw0.fmt == FMT_4DW_DATA)) &&
              (dw0.typ == TYPE_MEM) && (dw0.length == 10'd1) &&
              (dw1.first_be == 4'hF) && (dw1.last_be == 4'h0);
    addr_ok = ((addr ^ msi_base_addr) & msi_addr_mask & ~64'h3) == 64'h0;
    pass    = hdr_ok && addr_ok && enable && rx_tlp_eop && ((pay >> IRQ_INDEX_W) == 32'h0);
  end

  // Register the decode result of each sop beat (config sampled here)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_pass <= 1'b0;
      dec_bad  <= 1'b0;
      dec_idx  <= '0;
    end else begin
      dec_pass <= accept && rx_tlp_sop && pass;
      dec_bad  <= accept && rx_tlp_sop && !pass;
      if (accept && rx_tlp_sop) dec_idx <= pay[IRQ_INDEX_W-1:0];
    end
  end

  // Beat framing: single-beat TLPs stay idle, longer ones are drained to eop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      rx_tlp_ready <= 1'b0;
    end else begin
      rx_tlp_ready <= 1'b1;
      if (accept) begin
        if (rx_tlp_sop)
          state <= rx_tlp_eop ? ST_IDLE : ST_DISCARD;
        else if (state == ST_DISCARD && rx_tlp_eop)
          state <= ST_IDLE;
      end
    end
  end

  // A pop in the push cycle frees the slot being written
  assign pop           = m_axis_irq_tvalid && m_axis_irq_tready;
  assign push          = dec_pass && (!fifo_full || pop);
  assign stat_irq      = push;
  assign stat_drop_ovf = dec_pass && fifo_full && !pop;
  assign stat_drop_bad = dec_bad;

  // Overflow flag; a new overflow outranks a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                ovf_sticky <= 1'b0;
    else if (stat_drop_ovf) ovf_sticky <= 1'b1;
    else if (ovf_clear)     ovf_sticky <= 1'b0;
  end

  taxi_pcie_msix_rx_fifo #(
    .DATA_W (IRQ_INDEX_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_data   (dec_idx),
    .push      (push),
    .out_data  (m_axis_irq_tdata),
    .out_valid (m_axis_irq_tvalid),
    .out_ready (m_axis_irq_tready),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_taxi_pcie_msix_rx.sv
// Scoreboard bench for taxi_pcie_msix_rx: stimulus pushes expected indices,
// a negedge monitor pops and compares on every accepted output beat.
module tb_taxi_pcie_msix_rx;

  localparam int IW = 11;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [127:0]  rx_tlp_hdr = '0;
  logic [DW-1:0] rx_tlp_data = '0;
  logic          rx_tlp_sop = 1'b0, rx_tlp_eop = 1'b0, rx_tlp_valid = 1'b0;
  logic          rx_tlp_ready;
  logic [IW-1:0] m_axis_irq_tdata;
  logic          m_axis_irq_tvalid;
  logic          m_axis_irq_tready = 1'b1;
  logic [63:0]   msi_base_addr = 64'hFEE0_0000;
  logic [63:0]   msi_addr_mask = 64'hFFFF_FFFF_FFF0_0000;
  logic          enable = 1'b1;
  logic          stat_irq, stat_drop_bad, stat_drop_ovf, ovf_sticky;
  logic          ovf_clear = 1'b0;

  taxi_pcie_msix_rx #(.IRQ_INDEX_W(IW), .TLP_DATA_W(DW), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .rx_tlp_hdr(rx_tlp_hdr), .rx_tlp_data(rx_tlp_data),
    .rx_tlp_sop(rx_tlp_sop), .rx_tlp_eop(rx_tlp_eop),
    .rx_tlp_valid(rx_tlp_valid), .rx_tlp_ready(rx_tlp_ready),
    .m_axis_irq_tdata(m_axis_irq_tdata), .m_axis_irq_tvalid(m_axis_irq_tvalid),
    .m_axis_irq_tready(m_axis_irq_tready),
    .msi_base_addr(msi_base_addr), .msi_addr_mask(msi_addr_mask), .enable(enable),
    .stat_irq(stat_irq), .stat_drop_bad(stat_drop_bad), .stat_drop_ovf(stat_drop_ovf),
    .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int n_irq = 0, n_bad = 0, n_ovf = 0;
  int e_irq = 0, e_bad = 0, e_ovf = 0;
  logic [IW-1:0] sb [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: count stat pulses and check every accepted output beat
  always @(negedge clk) begin
    if (!rst) begin
      if (stat_irq)      n_irq++;
      if (stat_drop_bad) n_bad++;
      if (stat_drop_ovf) n_ovf++;
      if (m_axis_irq_tvalid && m_axis_irq_tready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL irq_unexpected: got %0h expected no output", m_axis_irq_tdata);
        end else begin
          chk("irq_tdata", {53'h0, m_axis_irq_tdata}, {53'h0, sb.pop_front()});
        end
      end
    end
  end

  function automatic logic [127:0] hdr3(input logic [31:0] a, input logic [9:0] len);
    return {3'b010, 5'b0, 14'b0, len, 16'h0100, 8'h00, 4'h0, 4'hF, a, 32'h0};
  endfunction

  function automatic logic [127:0] hdr4(input logic [63:0] a, input logic [9:0] len);
    return {3'b011, 5'b0, 14'b0, len, 16'h0100, 8'h00, 4'h0, 4'hF, a[63:32], a[31:0]};
  endfunction

  // One beat, driven just after a rising edge and accepted on the next one
  task automatic beat(input logic [127:0] h, input logic [31:0] d, input logic s, input logic e);
    rx_tlp_hdr = h; rx_tlp_data = {32'h0, d};
    rx_tlp_sop = s; rx_tlp_eop = e; rx_tlp_valid = 1'b1;
    @(posedge clk); #1;
    rx_tlp_valid = 1'b0; rx_tlp_sop = 1'b0; rx_tlp_eop = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic chk_stats();
    chk("stat_irq_count", n_irq, e_irq);
    chk("stat_bad_count", n_bad, e_bad);
    chk("stat_ovf_count", n_ovf, e_ovf);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    cycles(3);
    chk("rst_ready", rx_tlp_ready, 0);
    chk("rst_tvalid", m_axis_irq_tvalid, 0);
    chk("rst_tdata", m_axis_irq_tdata, 0);
    chk("rst_stats", {stat_irq, stat_drop_bad, stat_drop_ovf}, 0);
    chk("rst_ovf", ovf_sticky, 0);
    rst = 1'b0;
    cycles(1);
    chk("ready_after_rst", rx_tlp_ready, 1);

    // 3DW MWr in window, latency check
    sb.push_back(11'h5); e_irq++;
    beat(hdr3(32'hFEE0_1000, 10'd1), 32'h5, 1'b1, 1'b1);
    chk("c1_stat_irq_push_cycle", stat_irq, 1);
    cycles(1);
    chk("c1_tvalid_1cyc", m_axis_irq_tvalid, 0);
    chk("c1_stat_irq_once", stat_irq, 0);
    cycles(1);
    chk("c1_tvalid_2cyc", m_axis_irq_tvalid, 1);
    chk("c1_tdata", m_axis_irq_tdata, 11'h5);
    wait_drain();
    chk_stats();

    // 4DW MWr, max index then out-of-range index
    msi_base_addr = 64'h1_0000_0000;
    msi_addr_mask = 64'hFFFF_FFFF_0000_0000;
    sb.push_back(11'h7FF); e_irq++;
    beat(hdr4(64'h1_0000_0040, 10'd1), 32'h7FF, 1'b1, 1'b1);
    e_bad++;
    beat(hdr4(64'h1_0000_0040, 10'd1), 32'h800, 1'b1, 1'b1);
    cycles(4);
    wait_drain();
    chk_stats();

    // Address outside window, then decode disabled
    msi_base_addr = 64'hFEE0_0000;
    msi_addr_mask = 64'hFFFF_FFFF_FFF0_0000;
    e_bad++;
    beat(hdr3(32'hFEF0_0000, 10'd1), 32'h1, 1'b1, 1'b1);
    enable = 1'b0;
    e_bad++;
    beat(hdr3(32'hFEE0_1000, 10'd1), 32'h2, 1'b1, 1'b1);
    enable = 1'b1;
    cycles(4);
    chk("c3_no_output", m_axis_irq_tvalid, 0);
    chk_stats();

    // Two-beat length-3 TLP discarded, then a good write
    e_bad++;
    beat(hdr3(32'hFEE0_1000, 10'd3), 32'h9, 1'b1, 1'b0);
    beat(128'h0, 32'h9, 1'b0, 1'b1);
    sb.push_back(11'h3); e_irq++;
    beat(hdr3(32'hFEE0_1000, 10'd1), 32'h3, 1'b1, 1'b1);
    cycles(3);
    wait_drain();
    chk_stats();

    // Overflow: 17 writes into a stalled 16-deep FIFO
    m_axis_irq_tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) begin sb.push_back(i[IW-1:0]); e_irq++; end
      else e_ovf++;
      beat(hdr3(32'hFEE0_1000, 10'd1), i, 1'b1, 1'b1);
    end
    cycles(3);
    chk_stats();
    chk("ovf_sticky_set", ovf_sticky, 1);
    chk("ovf_head_valid", m_axis_irq_tvalid, 1);
    chk("ovf_head_data", m_axis_irq_tdata, 0);
    m_axis_irq_tready = 1'b1;
    wait_drain();
    chk("ovf_sticky_held", ovf_sticky, 1);
    ovf_clear = 1'b1;
    cycles(1);
    ovf_clear = 1'b0;
    chk("ovf_sticky_cleared", ovf_sticky, 0);

    // Reset during DISCARD with entries queued
    m_axis_irq_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(11'h11 + i[IW-1:0]); e_irq++;
      beat(hdr3(32'hFEE0_1000, 10'd1), 32'h11 + i, 1'b1, 1'b1);
    end
    cycles(3);
    chk("r_queued_valid", m_axis_irq_tvalid, 1);
    e_bad++;
    beat(hdr3(32'hFEE0_1000, 10'd3), 32'h1, 1'b1, 1'b0);
    beat(128'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("r_tvalid_async", m_axis_irq_tvalid, 0);
    chk("r_ready_async", rx_tlp_ready, 0);
    chk_stats();
    cycles(2);
    rst = 1'b0;
    m_axis_irq_tready = 1'b1;
    cycles(3);
    chk("r_fifo_empty", m_axis_irq_tvalid, 0);
    chk("r_ready_back", rx_tlp_ready, 1);
    sb.push_back(11'h2A); e_irq++;
    beat(hdr3(32'hFEE0_1000, 10'd1), 32'h2A, 1'b1, 1'b1);
    cycles(3);
    wait_drain();
    chk_stats();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/taxi_pcie_msix_rx.md
Name: taxi_pcie_msix_rx

Overview:
- Receive-side counterpart of the MSI-X generator: sinks memory-write TLPs, recognises MSI/MSI-X writes that hit a configured address window, and emits the interrupt vector index on an AXI-stream.
- Sits on the host/root-port side, or in loopback benches/SoC fabrics where PCIe interrupt writes are converted back into IRQ indices.
- Non-matching or malformed TLPs are consumed, dropped and flagged.

Parameters:
IRQ_INDEX_W, 11, width of the vector index output.
TLP_DATA_W, 64, TLP payload width (single segment, multiple of 32).
FIFO_DEPTH, 16, depth of the output IRQ FIFO (power of two, at least 2).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rx_tlp_hdr  in  128  TLP header; DW0 = [127:96], DW1 = [95:64], DW2 = [63:32], DW3 = [31:0]
rx_tlp_data  in  TLP_DATA_W  payload; first DW in [31:0]
rx_tlp_sop  in  1  first beat of TLP; header valid on this beat
rx_tlp_eop  in  1  last beat of TLP
rx_tlp_valid  in  1  beat valid
rx_tlp_ready  out  1  beat accepted when valid and ready
m_axis_irq_tdata  out  IRQ_INDEX_W  interrupt vector index
m_axis_irq_tvalid  out  1  index valid
m_axis_irq_tready  in  1  downstream ready
msi_base_addr  in  64  window base; bits [1:0] ignored
msi_addr_mask  in  64  window compare mask; 1 = compared bit
enable  in  1  decode enable; 0 = treat every TLP as non-matching
stat_irq  out  1  one-cycle pulse per index pushed into the FIFO
stat_drop_bad  out  1  one-cycle pulse per TLP that fails decode
stat_drop_ovf  out  1  one-cycle pulse per valid MSI write lost because the FIFO was full
ovf_sticky  out  1  set on overflow, cleared by ovf_clear
ovf_clear  in  1  clears ovf_sticky; a set in the same cycle wins

Behaviour:
- Reset (asynchronous assert, synchronous release): FSM goes to IDLE, FIFO empties. rx_tlp_ready=0, m_axis_irq_tvalid=0, tdata=0, all stat pulses=0, ovf_sticky=0.
- rx_tlp_ready is 1 in every cycle after reset; the block never backpressures and drops on overflow instead.
- FSM:
  - IDLE: on an accepted sop beat, decode the TLP. If eop is also set, stay in IDLE; otherwise go to DISCARD.
  - DISCARD: consume beats until eop, then return to IDLE. A sop arriving in DISCARD is a protocol error; treat it as a new TLP and decode it.
- Decode, all conditions required:
  - fmt=3'b010 (3DW address) or 3'b011 (4DW address), with type=5'b00000.
  - length=1.
  - first BE=4'hF and last BE=4'h0.
  - sop and eop on the same beat.
  - Address, from DW2[31:2] for 3DW or {DW2, DW3[31:2]} for 4DW with bits [1:0]=0, satisfies (addr & mask) == (base & mask).
  - enable=1.
  - payload DW0[31:IRQ_INDEX_W] all zero.
- Outcomes:
  - Pass with FIFO not full: push DW0[IRQ_INDEX_W-1:0] and pulse stat_irq.
  - Pass with FIFO full: discard, pulse stat_drop_ovf, set ovf_sticky.
  - Fail: pulse stat_drop_bad exactly once per TLP.
- Latency: decode is registered. The FIFO push occurs the cycle after the accepting beat, and m_axis_irq_tvalid rises 2 cycles after that beat if the FIFO was empty. Stat pulses are aligned with the push cycle.
- Full test uses the FIFO occupancy in the push cycle, so a same-cycle pop frees a slot and the push succeeds.
- FIFO: registered output with pointers of width log2(FIFO_DEPTH)+1 that wrap naturally. Sustains one push and one pop per cycle. Output order is strict arrival order.
- Config inputs are sampled on the sop beat; changing them mid-TLP has no effect on that TLP.

Decomposition:
- Shared package taxi_pcie_tlp_pkg holds the fmt/type localparams (FMT_3DW_DATA, FMT_4DW_DATA, TYPE_MEM), header field offsets, and a typedef for the unpacked DW0/DW1 header fields.
- One sub-module: taxi_pcie_msix_rx_fifo, the synchronous FIFO with full/empty flags and a registered output.

Test Plan:
- 3DW MWr, addr 0xFEE0_1000, base 0xFEE0_0000, mask 0xFFFF_FFFF_FFF0_0000, data 0x5, tready=1 -> tdata=5 with tvalid 2 cycles after the beat; stat_irq pulses once.
- 4DW MWr, addr 0x0000_0001_0000_0040, base 0x1_0000_0000, mask 0xFFFF_FFFF_0000_0000, data 0x7FF -> tdata=0x7FF; a second write with data 0x800 -> stat_drop_bad, no output.
- Address 0xFEF0_0000 with the same window as the first case, and separately enable=0 -> no output, one stat_drop_bad pulse each.
- MWr with length=3 over 2 beats, followed by a valid MWr data 0x3 -> first TLP discarded through eop with one stat_drop_bad; then tdata=3.
- tready=0, 17 back-to-back valid writes with data 0..16 -> 16 stat_irq pulses, one stat_drop_ovf, ovf_sticky=1; raise tready -> output 0..15 in order; ovf_clear -> ovf_sticky=0.
- Assert rst during the DISCARD of a multi-beat TLP with 3 entries queued -> tvalid=0 and rx_tlp_ready=0 immediately; after release the FIFO is empty and the next valid MWr decodes normally.
